exec_stage: RTL and testbench
=============================

# exec_stage

Execute stage of the 32-bit ARM pipeline. It consumes the decode-stage bundle, produces the second operand, runs the ALU, and holds the architectural status register, which it drives back to decode as `srOut`. It also resolves branches and drives `branchTaken` and `branchAddress` back to fetch. Results are registered into the EXE/MEM pipeline register for the memory stage.

## Interface
- No parameters. Data width is 32, register index width is 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wbEnIn`, `memrEnIn`, `memwEnIn`  in  1 each  control bits from decode.
- `sIn`  in  1  update-status request.
- `bIn`  in  1  branch instruction.
- `exeCmdIn`  in  4  ALU command.
- `pcIn`  in  32  PC+4 of the instruction.
- `rnValIn`, `rmValIn`  in  32 each  register operands.
- `immIn`  in  1  immediate-operand select.
- `shOprIn`  in  12  shifter operand.
- `signedImm24In`  in  24  branch offset in words.
- `destIn`  in  4  writeback register index.
- `branchTaken`  out  1  combinational; equals `bIn`.
- `branchAddress`  out  32  combinational branch target.
- `srOut`  out  4  registered status {N,Z,C,V}.
- `wbEnOut`, `memrEnOut`, `memwEnOut`  out  1 each  registered controls.
- `aluResOut`  out  32  registered ALU result or memory address.
- `storeValOut`  out  32  registered `rmValIn`, used as store data.
- `destOut`  out  4  registered destination index.

## Operation
- **Val2 when memory access** (`memrEnIn|memwEnIn`): val2 = zero-extended `shOprIn`.
- **Val2 when `immIn`=1**: val2 = {24'b0, `shOprIn[7:0]`} rotated right by 2×`shOprIn[11:8]`.
- **Val2 otherwise**: val2 = `rmValIn` shifted by `shOprIn[11:7]`, using the type in `shOprIn[6:5]`:
  - 00 = LSL
  - 01 = LSR
  - 10 = ASR
  - 11 = ROR
  - A shift of 0 passes `rmValIn` unchanged for every type.
- **exeCmd encoding:**
  - 0001 MOV: res = val2.
  - 1001 MVN: res = ~val2.
  - 0010 ADD: res = rn+val2.
  - 0011 ADC: res = rn+val2+C.
  - 0100 SUB/CMP: res = rn−val2.
  - 0101 SBC: res = rn−val2−(1−C).
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: res = 0, flags computed as for a logical op.
- C in ADC/SBC is the current `srOut[1]`.
- **Flags:**
  - N = res[31]; Z = (res == 0).
  - Add ops: C = carry out of bit 31; V = operands have the same sign and the result sign differs from it.
  - Sub ops: C = NOT borrow; V = operands have different signs and the result sign differs from rn.
  - Logical, MOV and MVN: C = 0, V = 0.
- **Status register:** loaded with the computed flags on the clock edge when `sIn`=1 and `bIn`=0. Otherwise it holds.
- **Branch:** `branchAddress` = `pcIn` + (sign-extended `signedImm24In` << 2), with 32-bit wrap-around. It is valid every cycle and qualified by `branchTaken`.
- **Pipeline register:** captures `wbEnIn`, `memrEnIn`, `memwEnIn`, res, `rmValIn` and `destIn` on every rising edge. There is no stall or flush input; flushing is done upstream by zeroing control bits.

## Timing
- Reset (`rst`=0, asynchronous): every registered output is 0 immediately and stays 0 while `rst` is low. This includes `srOut`=4'b0000.
- First capture happens at the first rising edge after `rst` deasserts.
- `branchTaken` and `branchAddress` have zero latency (same cycle as the inputs). `branchAddress` is undefined-free; it is computed even when `bIn`=0.
- ALU result to `aluResOut`: 1 cycle.
- Status update to `srOut`: 1 cycle. An instruction in the next cycle reads the updated flags; this is the flag-forwarding path for ADC/SBC back-to-back.
- Reset asserted mid-operation discards the in-flight result and the flags with no partial update.
- Simultaneous `sIn`=1 and `bIn`=1: flags hold and the branch resolves.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random inputs toggling.
  - All registered outputs are 0 and `srOut`=0000.
  - Assert `rst`=0 mid-stream: outputs clear without waiting for a clock edge.
- **ADD overflow:** `rnValIn`=0x7FFFFFFF, `immIn`=1, `shOprIn`=0x001, `exeCmdIn`=0010, `sIn`=1.
  - Next edge: `aluResOut`=0x80000000, `srOut`=1001.
- **CMP equal:** `rnValIn`=5, `rmValIn`=5, `shOprIn`=0x000, `exeCmdIn`=0100, `sIn`=1, `wbEnIn`=0.
  - Result 0, `srOut`=0110, `wbEnOut`=0.
- **Rotated immediate and shifts:**
  - MOV with `immIn`=1, `shOprIn`=0x2FF gives `aluResOut`=0xF000000F.
  - MOV with `immIn`=0, `rmValIn`=0x80000001, `shOprIn`={5'd1,2'b10,5'b0} (ASR #1) gives 0xC0000000.
  - The same with ROR #1 gives 0xC0000000.
- **Branch:** `bIn`=1, `pcIn`=0x100, `signedImm24In`=0xFFFFFE, `sIn`=1.
  - Same cycle: `branchTaken`=1, `branchAddress`=0x000000F8.
  - `srOut` unchanged after the edge.
- **LDR address and flag hold:** `memrEnIn`=1, `rnValIn`=0x400, `shOprIn`=0x004, `exeCmdIn`=0010, `sIn`=0.
  - Next edge: `aluResOut`=0x404, `memrEnOut`=1, `srOut` unchanged.
  - Then ADC with `sIn`=0 after C=1 is set: result includes +1.

Source files
------------

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage
// Execute stage of the 32-bit ARM pipeline. It forms the second ALU operand
// (memory offset, rotated immediate or shifted register), runs the ALU, owns the
// {N,Z,C,V} status register and resolves branch targets. Results go into the
// EXE/MEM pipeline register on every rising clock edge.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   wbEnIn/memrEnIn/memwEnIn    control bits from decode
//   sIn, bIn                    update-status request, branch instruction
//   exeCmdIn[3:0]               ALU command
//   pcIn[31:0]                  PC+4 of the instruction
//   rnValIn, rmValIn[31:0]      register operands
//   immIn, shOprIn[11:0]        immediate select, shifter operand
//   signedImm24In[23:0]         branch offset in words
//   destIn[3:0]                 writeback register index
//   branchTaken, branchAddress  combinational branch resolution to fetch
//   srOut[3:0]                  registered status {N,Z,C,V} back to decode
//   wbEnOut/memrEnOut/memwEnOut registered controls
//   aluResOut, storeValOut      registered ALU result / store data
//   destOut[3:0]                registered destination index
// -----------------------------------------------------------------------------
module exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEnIn,
    input  logic        memrEnIn,
    input  logic        memwEnIn,
    input  logic        sIn,
    input  logic        bIn,
    input  logic [3:0]  exeCmdIn,
    input  logic [31:0] pcIn,
    input  logic [31:0] rnValIn,
    input  logic [31:0] rmValIn,
    input  logic        immIn,
    input  logic [11:0] shOprIn,
    input  logic [23:0] signedImm24In,
    input  logic [3:0]  destIn,
    output logic        branchTaken,
    output logic [31:0] branchAddress,
    output logic [3:0]  srOut,
    output logic        wbEnOut,
    output logic        memrEnOut,
    output logic        memwEnOut,
    output logic [31:0] aluResOut,
    output logic [31:0] storeValOut,
    output logic [3:0]  destOut
);

    // Rotate right; a zero amount leaves x unchanged because x << 32 is 0.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] a);
        ror32 = (x >> a) | (x << (6'd32 - {1'b0, a}));
    endfunction

    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [3:0]  flags_next;
    logic [32:0] sum;
    logic        carry_in;

    // ---------------- second operand ----------------
    always_comb begin
        val2 = rmValIn;
        if (memrEnIn || memwEnIn) begin
            // Load/store offset is the raw 12-bit field, never rotated.
            val2 = {20'b0, shOprIn};
        end else if (immIn) begin
            val2 = ror32({24'b0, shOprIn[7:0]}, {shOprIn[11:8], 1'b0});
        end else begin
            case (shOprIn[6:5])
                2'b00:   val2 = rmValIn << shOprIn[11:7];
                2'b01:   val2 = rmValIn >> shOprIn[11:7];
                2'b10:   val2 = $unsigned($signed(rmValIn) >>> shOprIn[11:7]);
                default: val2 = ror32(rmValIn, shOprIn[11:7]);
            endcase
        end
    end

    // ---------------- ALU and flags ----------------
    assign carry_in = srOut[1];

    always_comb begin
        sum        = 33'b0;
        alu_res    = 32'b0;
        flags_next = 4'b0000;
        case (exeCmdIn)
            4'b0010, 4'b0011: begin
                sum     = {1'b0, rnValIn} + {1'b0, val2}
                          + {32'b0, (exeCmdIn == 4'b0011) & carry_in};
                alu_res = sum[31:0];
                flags_next[1] = sum[32];
                flags_next[0] = (rnValIn[31] == val2[31]) && (alu_res[31] != rnValIn[31]);
            end
            4'b0100, 4'b0101: begin
                // rn - val2 - borrow_in done as rn + ~val2 + carry_in, so the
                // carry out is directly NOT borrow.
                sum     = {1'b0, rnValIn} + {1'b0, ~val2}
                          + {32'b0, (exeCmdIn == 4'b0100) | carry_in};
                alu_res = sum[31:0];
                flags_next[1] = sum[32];
                flags_next[0] = (rnValIn[31] != val2[31]) && (alu_res[31] != rnValIn[31]);
            end
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0110: alu_res = rnValIn & val2;
            4'b0111: alu_res = rnValIn | val2;
            4'b1000: alu_res = rnValIn ^ val2;
            default: alu_res = 32'b0;
        endcase
        flags_next[3] = alu_res[31];
        flags_next[2] = (alu_res == 32'b0);
    end

    // ---------------- branch resolution ----------------
    assign branchTaken   = bIn;
    assign branchAddress = pcIn + {{6{signedImm24In[23]}}, signedImm24In, 2'b00};

    // ---------------- status and pipeline registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            srOut       <= 4'b0000;
            wbEnOut     <= 1'b0;
            memrEnOut   <= 1'b0;
            memwEnOut   <= 1'b0;
            aluResOut   <= 32'b0;
            storeValOut <= 32'b0;
            destOut     <= 4'b0;
        end else begin
            // A branch that also requests S keeps the flags untouched.
            if (sIn && !bIn) begin
                srOut <= flags_next;
            end
            wbEnOut     <= wbEnIn;
            memrEnOut   <= memrEnIn;
            memwEnOut   <= memwEnIn;
            aluResOut   <= alu_res;
            storeValOut <= rmValIn;
            destOut     <= destIn;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbEnIn = 0, memrEnIn = 0, memwEnIn = 0, sIn = 0, bIn = 0, immIn = 0;
    logic [3:0]  exeCmdIn = 0, destIn = 0;
    logic [31:0] pcIn = 0, rnValIn = 0, rmValIn = 0;
    logic [11:0] shOprIn = 0;
    logic [23:0] signedImm24In = 0;
    logic        branchTaken;
    logic [31:0] branchAddress;
    logic [3:0]  srOut;
    logic        wbEnOut, memrEnOut, memwEnOut;
    logic [31:0] aluResOut, storeValOut;
    logic [3:0]  destOut;

    exec_stage dut (
        .clk(clk), .rst(rst),
        .wbEnIn(wbEnIn), .memrEnIn(memrEnIn), .memwEnIn(memwEnIn),
        .sIn(sIn), .bIn(bIn), .exeCmdIn(exeCmdIn), .pcIn(pcIn),
        .rnValIn(rnValIn), .rmValIn(rmValIn), .immIn(immIn), .shOprIn(shOprIn),
        .signedImm24In(signedImm24In), .destIn(destIn),
        .branchTaken(branchTaken), .branchAddress(branchAddress), .srOut(srOut),
        .wbEnOut(wbEnOut), .memrEnOut(memrEnOut), .memwEnOut(memwEnOut),
        .aluResOut(aluResOut), .storeValOut(storeValOut), .destOut(destOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  sr;
        logic        wb, mr, mw;
        logic [31:0] store;
        logic [3:0]  dest;
    } exp_t;

    exp_t exp_q[$];
    logic chk_flag = 1'b0;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s: got %h expected %h", name, act, req);
        else
            passed++;
    endtask

    // Drive one instruction on a falling edge and queue its expected EXE/MEM contents.
    task automatic issue(input string name, input logic wb, input logic mr, input logic mw,
                         input logic s, input logic b, input logic imm, input logic [3:0] cmd,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sh,
                         input logic [3:0] dest, input logic [31:0] e_res, input logic [3:0] e_sr);
        exp_t e;
        @(negedge clk);
        wbEnIn = wb; memrEnIn = mr; memwEnIn = mw; sIn = s; bIn = b; immIn = imm;
        exeCmdIn = cmd; rnValIn = rn; rmValIn = rm; shOprIn = sh; destIn = dest;
        e.name = name; e.res = e_res; e.sr = e_sr; e.wb = wb; e.mr = mr; e.mw = mw;
        e.store = rm; e.dest = dest;
        exp_q.push_back(e);
        chk_flag = 1'b1;
        $display("issue %-10s cmd=%b rn=%h rm=%h sh=%h -> res=%h sr=%b", name, cmd, rn, rm, sh, e_res, e_sr);
    endtask

    task automatic go_idle();
        @(negedge clk);
        chk_flag = 1'b0;
        wbEnIn = 0; memrEnIn = 0; memwEnIn = 0; sIn = 0; bIn = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res"},   aluResOut, 32'h0);
        chk({tag, "_sr"},    {28'h0, srOut}, 32'h0);
        chk({tag, "_ctl"},   {29'h0, wbEnOut, memrEnOut, memwEnOut}, 32'h0);
        chk({tag, "_store"}, storeValOut, 32'h0);
        chk({tag, "_dest"},  {28'h0, destOut}, 32'h0);
    endtask

    // Monitor: each edge that captured a tagged instruction yields one compare set.
    initial begin
        forever begin
            logic pend;
            exp_t e;
            @(posedge clk);
            pend = chk_flag;
            #1;
            if (pend) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL scoreboard_underflow: got output with empty queue");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_res"},   aluResOut, e.res);
                    chk({e.name, "_sr"},    {28'h0, srOut}, {28'h0, e.sr});
                    chk({e.name, "_ctl"},   {29'h0, wbEnOut, memrEnOut, memwEnOut},
                                            {29'h0, e.wb, e.mr, e.mw});
                    chk({e.name, "_store"}, storeValOut, e.store);
                    chk({e.name, "_dest"},  {28'h0, destOut}, {28'h0, e.dest});
                    $display("check %-10s res=%h sr=%b", e.name, aluResOut, srOut);
                end
            end
        end
    end

    initial begin
        // Reset held low with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wbEnIn = 1'($urandom); memrEnIn = 1'($urandom); memwEnIn = 1'($urandom);
            sIn = 1'($urandom); exeCmdIn = 4'($urandom); rnValIn = $urandom;
            rmValIn = $urandom; shOprIn = 12'($urandom); destIn = 4'($urandom);
            #1 chk_all_zero("reset");
        end
        @(negedge clk);
        rst = 1'b1;

        issue("add_ovf", 1,0,0, 1,0,1, 4'b0010, 32'h7FFFFFFF, 32'h11111111, 12'h001, 4'd3, 32'h80000000, 4'b1001);
        issue("cmp_eq",  0,0,0, 1,0,0, 4'b0100, 32'd5, 32'd5, 12'h000, 4'd2, 32'h0, 4'b0110);
        issue("mov_rimm",1,0,0, 0,0,1, 4'b0001, 32'h0, 32'h0, 12'h2FF, 4'd1, 32'hF000000F, 4'b0110);
        issue("mov_asr", 1,0,0, 0,0,0, 4'b0001, 32'h0, 32'h80000001, 12'h0C0, 4'd4, 32'hC0000000, 4'b0110);
        issue("mov_ror", 1,0,0, 0,0,0, 4'b0001, 32'h0, 32'h80000001, 12'h0E0, 4'd4, 32'hC0000000, 4'b0110);
        pcIn = 32'h100; signedImm24In = 24'hFFFFFE;
        issue("branch",  0,0,0, 1,1,1, 4'b0010, 32'h0, 32'h0, 12'h000, 4'd0, 32'h0, 4'b0110);
        #1;
        chk("branch_taken", {31'h0, branchTaken}, 32'h1);
        chk("branch_addr", branchAddress, 32'h000000F8);
        pcIn = 32'h0; signedImm24In = 24'h0;
        issue("ldr_addr",1,1,0, 0,0,0, 4'b0010, 32'h400, 32'hDEADBEEF, 12'h004, 4'd5, 32'h404, 4'b0110);
        issue("adc_c1",  1,0,0, 0,0,1, 4'b0011, 32'd10, 32'h0, 12'h005, 4'd6, 32'd16, 4'b0110);
        issue("sbc_c1",  1,0,0, 1,0,1, 4'b0101, 32'd10, 32'h0, 12'h005, 4'd6, 32'd5, 4'b0010);
        issue("add_c0",  1,0,0, 1,0,1, 4'b0010, 32'd1, 32'h0, 12'h001, 4'd7, 32'd2, 4'b0000);
        issue("adc_c0",  1,0,0, 0,0,1, 4'b0011, 32'd1, 32'h0, 12'h001, 4'd7, 32'd2, 4'b0000);
        issue("mvn",     1,0,0, 1,0,1, 4'b1001, 32'h0, 32'h0, 12'h000, 4'd8, 32'hFFFFFFFF, 4'b1000);
        issue("lsl4",    1,0,0, 1,0,0, 4'b0001, 32'h0, 32'h1, 12'h200, 4'd9, 32'h10, 4'b0000);
        issue("lsr31",   1,0,0, 0,0,0, 4'b0001, 32'h0, 32'h80000000, 12'hFA0, 4'd9, 32'h1, 4'b0000);
        issue("and",     1,0,0, 1,0,0, 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 4'd10, 32'hF000F000, 4'b1000);
        issue("orr",     1,0,0, 0,0,0, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 4'd10, 32'hFFF0FFF0, 4'b1000);
        issue("eor",     1,0,0, 0,0,0, 4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 4'd10, 32'h0FF00FF0, 4'b1000);
        issue("undef",   1,0,0, 1,0,0, 4'b1111, 32'h12345678, 32'h9, 12'h000, 4'd11, 32'h0, 4'b0100);
        issue("sub_brw", 1,0,0, 1,0,1, 4'b0100, 32'd3, 32'h0, 12'h005, 4'd12, 32'hFFFFFFFE, 4'b1000);
        issue("sub_ovf", 1,0,0, 1,0,1, 4'b0100, 32'h80000000, 32'h0, 12'h001, 4'd12, 32'h7FFFFFFF, 4'b0011);
        issue("sbc_nob", 1,0,0, 0,0,1, 4'b0101, 32'h10, 32'h0, 12'h001, 4'd13, 32'hF, 4'b0011);
        issue("str_off", 0,0,1, 0,0,1, 4'b0010, 32'h0, 32'hCAFEF00D, 12'hFFF, 4'd14, 32'hFFF, 4'b0011);
        go_idle();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        else
            passed++;

        // Load nonzero state, then reset between clock edges.
        issue("pre_rst", 1,0,1, 1,0,1, 4'b0010, 32'h80000000, 32'h55, 12'h001, 4'd15, 32'h80000001, 4'b1000);
        go_idle();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue("adc_post",1,0,0, 0,0,1, 4'b0011, 32'd1, 32'h0, 12'h001, 4'd1, 32'd2, 4'b0000);
        go_idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0)
            $display("FAIL final_drain: got %0d pending expected 0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
